// File: rtl/rename_free_list_ctrl.sv
// Register rename controller: speculative/committed arch->phys maps, FIFO free list of
// physical tags, and per-tag busy bits with flush recovery to committed state.
module rename_free_list_ctrl #(
   parameter int unsigned ARCH_REGS = 32,
   parameter int unsigned PHYS_REGS = 64,
   parameter int unsigned TAG_W     = $clog2(PHYS_REGS),
   localparam int unsigned ARCH_W   = $clog2(ARCH_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_req,
   input  logic [ARCH_W-1:0] alloc_arch,
   output logic              alloc_grant,
   output logic [TAG_W-1:0]  alloc_phys,
   output logic [TAG_W-1:0]  alloc_old_phys,
   input  logic [ARCH_W-1:0] rs_arch,
   input  logic [ARCH_W-1:0] rt_arch,
   output logic [TAG_W-1:0]  rs_phys,
   output logic [TAG_W-1:0]  rt_phys,
   output logic              rs_busy,
   output logic              rt_busy,
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_phys,
   input  logic              commit_valid,
   input  logic [ARCH_W-1:0] commit_arch,
   input  logic [TAG_W-1:0]  commit_phys,
   input  logic [TAG_W-1:0]  commit_old_phys,
   input  logic              flush,
   output logic [TAG_W-1:0]  free_count
);

   localparam int unsigned DEPTH = PHYS_REGS - ARCH_REGS;
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [ARCH_REGS-1:0][TAG_W-1:0] spec_map;
   logic [ARCH_REGS-1:0][TAG_W-1:0] com_map;
   logic [DEPTH-1:0][TAG_W-1:0]     fifo;
   logic [PHYS_REGS-1:0]            busy;
   logic [PTR_W-1:0]                head;
   logic [PTR_W-1:0]                tail;
   logic [PTR_W-1:0]                ret_head;
   logic [TAG_W-1:0]                count;
   logic [TAG_W-1:0]                count_d;
   logic                            do_alloc;
   logic                            do_commit;

   assign do_commit   = commit_valid & (commit_arch != '0);
   assign alloc_grant = alloc_req & ~flush & ((alloc_arch == '0) | (count != '0));
   assign do_alloc    = alloc_grant & (alloc_arch != '0);

   assign alloc_phys     = (alloc_arch == '0) ? '0 : fifo[head];
   assign alloc_old_phys = (alloc_arch == '0) ? '0 : spec_map[alloc_arch];

   // Lookups see the current map only; a same-cycle writeback clears busy early.
   assign rs_phys = (rs_arch == '0) ? '0 : spec_map[rs_arch];
   assign rt_phys = (rt_arch == '0) ? '0 : spec_map[rt_arch];
   assign rs_busy = (rs_arch != '0) & busy[rs_phys] & ~(wb_valid & (wb_phys == rs_phys));
   assign rt_busy = (rt_arch != '0) & busy[rt_phys] & ~(wb_valid & (wb_phys == rt_phys));

   assign free_count = count;

   always_comb begin
      count_d = count;
      if (flush) begin
         count_d = TAG_W'(DEPTH);
      end else begin
         unique case ({do_alloc, do_commit})
            2'b10:   count_d = count - TAG_W'(1);
            2'b01:   count_d = count + TAG_W'(1);
            default: count_d = count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ARCH_REGS; i++) begin
            spec_map[i] <= TAG_W'(i);
            com_map[i]  <= TAG_W'(i);
         end
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo[i] <= TAG_W'(ARCH_REGS + i);
         end
         busy     <= '0;
         head     <= '0;
         tail     <= '0;
         ret_head <= '0;
         count    <= TAG_W'(DEPTH);
      end else begin
         if (do_commit) begin
            fifo[tail]           <= commit_old_phys;
            tail                 <= tail + PTR_W'(1);
            ret_head             <= ret_head + PTR_W'(1);
            com_map[commit_arch] <= commit_phys;
         end
         if (flush) begin
            // Recover from committed state including this cycle's commit.
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
               spec_map[i] <= (do_commit && commit_arch == ARCH_W'(i)) ? commit_phys
                                                                       : com_map[i];
            end
            head <= ret_head + PTR_W'(do_commit);
            busy <= '0;
         end else begin
            if (wb_valid && wb_phys != '0) busy[wb_phys] <= 1'b0;
            if (do_alloc) begin
               spec_map[alloc_arch] <= fifo[head];
               busy[fifo[head]]     <= 1'b1;
               head                 <= head + PTR_W'(1);
            end
         end
         count <= count_d;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      (do_commit && !do_alloc) |-> (count != TAG_W'(DEPTH)));

   a_no_wb_alloc_clash: assert property (@(posedge clk) disable iff (rst)
      !(do_alloc && wb_valid && wb_phys != '0 && wb_phys == fifo[head]));

endmodule

// File: doc/rename_free_list_ctrl.md
Name: rename_free_list_ctrl

Overview:
- Rename controller for the physical register file.
- Owns the speculative map table (arch→phys), the committed map table, a FIFO free list of physical tags, and per-tag busy bits.
- Sits between decode and the register file. It hands out destination tags at rename, answers source lookups with tag and busy, clears busy on writeback, recycles old tags on commit, and restores committed state on flush.

Parameters:
- ARCH_REGS, 32, architectural registers; arch 0 is never renamed.
- PHYS_REGS, 64, physical registers; free-list depth = PHYS_REGS-ARCH_REGS.
- TAG_W, 6, physical tag width, $clog2(PHYS_REGS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_req  in  1  rename wants a destination tag
- alloc_arch  in  5  destination arch register
- alloc_grant  out  1  tag granted this cycle
- alloc_phys  out  TAG_W  newly allocated tag
- alloc_old_phys  out  TAG_W  previous mapping of alloc_arch, carried to commit
- rs_arch, rt_arch  in  5 each  source lookups
- rs_phys, rt_phys  out  TAG_W each  current speculative mapping
- rs_busy, rt_busy  out  1 each  source value not yet written back
- wb_valid  in  1  writeback of a physical tag
- wb_phys  in  TAG_W  tag written
- commit_valid  in  1  in-order retirement of one renamed instruction
- commit_arch  in  5  its arch destination
- commit_phys  in  TAG_W  its new tag
- commit_old_phys  in  TAG_W  tag to free
- flush  in  1  squash all uncommitted renames
- free_count  out  TAG_W  entries in free list

Behaviour:
- Reset (rst high at posedge; overrides every other input):
  - both maps[i] = i; all busy = 0.
  - free list holds tags ARCH_REGS..PHYS_REGS-1 in ascending order; head = 0, tail = 0, ret_head = 0.
  - free_count = PHYS_REGS-ARCH_REGS (32).
- Lookups are combinational from the speculative map. A same-cycle alloc to the same arch is NOT forwarded, so `add r1,r1,r2` reads the old r1 tag.
- Busy output: rs_busy = busy[rs_phys] & ~(wb_valid & wb_phys==rs_phys); rt_busy likewise. Arch 0 always gives phys 0, busy 0.
- Alloc:
  - alloc_grant = alloc_req & ~flush & (alloc_arch==0 | free_count!=0).
  - For arch≠0: alloc_phys = fifo[head] and alloc_old_phys = map[alloc_arch], both combinational. At the edge: map[alloc_arch] ← alloc_phys, busy[alloc_phys] ← 1, head+1 with wrap at depth, count−1.
  - For arch 0: grant with alloc_phys = alloc_old_phys = 0; no state change.
  - No grant when empty; a same-cycle commit push does not bypass. The requester holds alloc_req until granted.
- Writeback: busy[wb_phys] ← 0 at the edge, ignored for tag 0.
  - If alloc sets the same tag in the same cycle, the set wins. This is illegal by construction and must be asserted.
- Commit (arch≠0):
  - fifo[tail] ← commit_old_phys, tail+1, count+1.
  - committed_map[commit_arch] ← commit_phys; ret_head+1.
  - Commit with arch 0: no effect.
- Alloc and commit in the same cycle: count unchanged, both pointers advance.
- free_count never exceeds the depth; assert on push when full.
- Flush:
  - The same-cycle commit is applied first.
  - map ← updated committed_map; head ← updated ret_head; count ← PHYS_REGS-ARCH_REGS; all busy ← 0.
  - Same-cycle alloc is denied; same-cycle wb is ignored.
  - Invariant: exactly ARCH_REGS tags are committed-mapped, so the tags between ret_head and head are precisely the speculative ones and return to the list.
- Pointers are $clog2(depth) bits and wrap naturally. Count is TAG_W bits.

Test Plan:
- Reset, then alloc arch 3 → grant=1, alloc_phys=32, alloc_old_phys=3; next cycle rs_arch=3 gives rs_phys=32, rs_busy=1, free_count=31.
- wb_phys=32 while rs_arch=3 is looked up → rs_busy=0 in the same cycle; busy[32]=0 next cycle.
- 32 allocs to arch 1..31 with no commit → free_count=0; 33rd alloc_req gives grant=0. A commit with old_phys=1 → next cycle grant=1, alloc_phys=1.
- Alloc and commit in the same cycle at free_count=10 → free_count stays 10; head and tail both +1.
- Alloc arch 5→32 and 6→33, commit only the first (old 5), then flush → map[5]=32, map[6]=6, head=ret_head=1, free_count=32, all busy 0; next alloc returns 33.
- Alloc arch 0 → grant=1, phys 0, free_count unchanged. rst asserted mid-stream with pending alloc/commit → all state returns to reset values next cycle.
